mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 238 +++++++++++++++++++++++
 tb/tb_mem_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage of a 5-stage RV32I pipeline: issues loads/stores to the data
// memory and waits for the one-cycle dmem_resp pulse. It aligns store data and
// loaded data to byte lanes, selects the regfile write value, and holds the
// MEM/WB register. It also forwards from MEM/WB and runs an optional sticky
// watchdog (DMEM_TIMEOUT) on outstanding accesses.
// Optional build macro: MEM_ALIGN_CHECK_EN. When defined, a misaligned halfword
// or word access is squashed: no memory request, no stall, regfile_write cleared.

package mem_stage_pkg;
  typedef enum logic [2:0] {
    RF_ALU  = 3'd0,
    RF_BR   = 3'd1,
    RF_UIMM = 3'd2,
    RF_PC4  = 3'd3,
    RF_LOAD = 3'd4
  } regfilemux_sel_t;

  typedef struct packed {
    logic            mem_read;
    logic            mem_write;
    logic [2:0]      funct3;
    logic            regfile_write;
    regfilemux_sel_t regfilemux_sel;
  } rv32i_ctrl_word;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DMEM_TIMEOUT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ex_valid,
  input  rv32i_ctrl_word ex_ctrlword,
  input  logic [31:0]    ex_alu_out,
  input  logic [31:0]    ex_i_rs2,
  input  logic [31:0]    ex_u_imm,
  input  logic [31:0]    ex_pc,
  input  logic           ex_br_en,
  input  logic [4:0]     ex_rd_addr,
  output logic           mem_stall,
  output logic [31:0]    dmem_address,
  output logic           dmem_read,
  output logic           dmem_write,
  output logic [3:0]     dmem_wmask,
  output logic [31:0]    dmem_wdata,
  input  logic [31:0]    dmem_rdata,
  input  logic           dmem_resp,
  output logic [4:0]     mem_fwd_rs_addr,
  output logic [31:0]    mem_fwd_rs_data,
  output logic           wb_valid,
  output rv32i_ctrl_word wb_ctrlword,
  output logic [4:0]     wb_rd_addr,
  output logic [31:0]    wb_data,
  output logic           mem_timeout
);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t         state_reg;
  logic           req_read_reg, req_write_reg;
  logic [31:0]    req_addr_reg, req_wdata_reg;
  logic [3:0]     req_wmask_reg;
  logic [2:0]     req_funct3_reg;
  logic [1:0]     req_offset_reg;
  logic [31:0]    wd_cnt_reg;
  logic           mem_timeout_reg;
  logic           wb_valid_reg;
  rv32i_ctrl_word wb_ctrl_reg;
  logic [4:0]     wb_rd_addr_reg;
  logic [31:0]    wb_data_reg;

  logic           is_mem_op, misaligned, mem_req, in_wait;
  logic [3:0]     issue_wmask;
  logic [31:0]    issue_wdata, load_value, wb_data_next;
  logic [15:0]    load_half;
  logic [7:0]     rdata_byte [4];
  rv32i_ctrl_word wb_ctrl_next;

  assign is_mem_op = ex_valid & (ex_ctrlword.mem_read | ex_ctrlword.mem_write);
  assign in_wait   = (state_reg == WAIT);

`ifdef MEM_ALIGN_CHECK_EN
  // Flag halfword accesses on odd addresses and word accesses off a word boundary
  always_comb begin
    misaligned = 1'b0;
    if (is_mem_op) begin
      case (ex_ctrlword.funct3[1:0])
        2'b01:   misaligned = ex_alu_out[0];
        2'b10:   misaligned = |ex_alu_out[1:0];
        default: misaligned = 1'b0;
      endcase
    end
  end
`else
  assign misaligned = 1'b0;
`endif

  assign mem_req = is_mem_op & ~misaligned;

  // Build the byte-lane mask and replicated store data for the access in EX
  always_comb begin
    issue_wmask = 4'b0000;
    issue_wdata = 32'h0;
    if (ex_ctrlword.mem_write) begin
      case (ex_ctrlword.funct3[1:0])
        2'b00: begin
          issue_wmask = 4'b0001 << ex_alu_out[1:0];
          issue_wdata = {4{ex_i_rs2[7:0]}};
        end
        2'b01: begin
          issue_wmask = 4'b0011 << ex_alu_out[1:0];
          issue_wdata = {2{ex_i_rs2[15:0]}};
        end
        default: begin
          issue_wmask = 4'b1111;
          issue_wdata = ex_i_rs2;
        end
      endcase
    end
  end

  // Request is combinational in IDLE, then replayed from the captured copy in
  // WAIT so the memory sees a stable request. Reset kills it immediately.
  assign dmem_read    = ~rst & (in_wait ? req_read_reg  : (mem_req & ex_ctrlword.mem_read));
  assign dmem_write   = ~rst & (in_wait ? req_write_reg : (mem_req & ex_ctrlword.mem_write));
  assign dmem_address = in_wait ? req_addr_reg  : {ex_alu_out[31:2], 2'b00};
  assign dmem_wmask   = in_wait ? req_wmask_reg : issue_wmask;
  assign dmem_wdata   = in_wait ? req_wdata_reg : issue_wdata;
  assign mem_stall    = in_wait ? ~dmem_resp    : mem_req;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign rdata_byte[gi] = dmem_rdata[8*gi +: 8];
    end
  endgenerate

  assign load_half = req_offset_reg[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  // Extract and extend the loaded value using the captured funct3 and offset
  always_comb begin
    case (req_funct3_reg)
      3'b000:  load_value = {{24{rdata_byte[req_offset_reg][7]}}, rdata_byte[req_offset_reg]};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b100:  load_value = {24'h0, rdata_byte[req_offset_reg]};
      3'b101:  load_value = {16'h0, load_half};
      default: load_value = dmem_rdata;
    endcase
  end

  // Select the final regfile write value and squash writes of rejected accesses
  always_comb begin
    case (ex_ctrlword.regfilemux_sel)
      RF_ALU:  wb_data_next = ex_alu_out;
      RF_BR:   wb_data_next = {31'h0, ex_br_en};
      RF_UIMM: wb_data_next = ex_u_imm;
      RF_PC4:  wb_data_next = ex_pc + 32'd4;
      RF_LOAD: wb_data_next = load_value;
      default: wb_data_next = ex_alu_out;
    endcase
    wb_ctrl_next = ex_ctrlword;
    wb_ctrl_next.regfile_write = ex_ctrlword.regfile_write & ~misaligned;
  end

  // Access FSM: capture the request on issue, return to IDLE on the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      req_read_reg   <= 1'b0;
      req_write_reg  <= 1'b0;
      req_addr_reg   <= 32'h0;
      req_wmask_reg  <= 4'h0;
      req_wdata_reg  <= 32'h0;
      req_funct3_reg <= 3'h0;
      req_offset_reg <= 2'h0;
    end else begin
      case (state_reg)
        IDLE: if (mem_req) begin
          state_reg      <= WAIT;
          req_read_reg   <= ex_ctrlword.mem_read;
          req_write_reg  <= ex_ctrlword.mem_write;
          req_addr_reg   <= {ex_alu_out[31:2], 2'b00};
          req_wmask_reg  <= issue_wmask;
          req_wdata_reg  <= issue_wdata;
          req_funct3_reg <= ex_ctrlword.funct3;
          req_offset_reg <= ex_alu_out[1:0];
        end
        WAIT: if (dmem_resp) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Watchdog: count cycles spent waiting; flag stays set until reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_reg      <= 32'h0;
      mem_timeout_reg <= 1'b0;
    end else if (in_wait) begin
      if (wd_cnt_reg != 32'hFFFF_FFFF) wd_cnt_reg <= wd_cnt_reg + 32'd1;
      if ((DMEM_TIMEOUT != 32'd0) && (wd_cnt_reg + 32'd1 >= DMEM_TIMEOUT))
        mem_timeout_reg <= 1'b1;
    end else begin
      wd_cnt_reg <= 32'h0;
    end
  end

  // MEM/WB register: advance when not stalled, insert a bubble while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_reg   <= 1'b0;
      wb_ctrl_reg    <= '0;
      wb_rd_addr_reg <= 5'h0;
      wb_data_reg    <= 32'h0;
    end else if (mem_stall) begin
      wb_valid_reg <= 1'b0;
    end else begin
      wb_valid_reg   <= ex_valid;
      wb_ctrl_reg    <= wb_ctrl_next;
      wb_rd_addr_reg <= ex_rd_addr;
      wb_data_reg    <= wb_data_next;
    end
  end

  logic fwd_en;
  assign fwd_en          = wb_valid_reg & wb_ctrl_reg.regfile_write & (wb_rd_addr_reg != 5'd0);
  assign mem_fwd_rs_addr = fwd_en ? wb_rd_addr_reg : 5'd0;
  assign mem_fwd_rs_data = fwd_en ? wb_data_reg : 32'h0;

  assign wb_valid    = wb_valid_reg;
  assign wb_ctrlword = wb_ctrl_reg;
  assign wb_rd_addr  = wb_rd_addr_reg;
  assign wb_data     = wb_data_reg;
  assign mem_timeout = mem_timeout_reg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage (DMEM_TIMEOUT = 4). Covers the ALU/branch/
// U-imm/PC+4 writeback paths, loads and stores with lane handling, stall
// timing, reset during an outstanding access, stray responses, and the
// watchdog. The misaligned-access case runs when MEM_ALIGN_CHECK_EN is defined.

module tb_mem_stage;
  import mem_stage_pkg::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           ex_valid;
  rv32i_ctrl_word ex_ctrlword;
  logic [31:0]    ex_alu_out, ex_i_rs2, ex_u_imm, ex_pc;
  logic           ex_br_en;
  logic [4:0]     ex_rd_addr;
  logic           mem_stall;
  logic [31:0]    dmem_address;
  logic           dmem_read, dmem_write;
  logic [3:0]     dmem_wmask;
  logic [31:0]    dmem_wdata;
  logic [31:0]    dmem_rdata;
  logic           dmem_resp;
  logic [4:0]     mem_fwd_rs_addr;
  logic [31:0]    mem_fwd_rs_data;
  logic           wb_valid;
  rv32i_ctrl_word wb_ctrlword;
  logic [4:0]     wb_rd_addr;
  logic [31:0]    wb_data;
  logic           mem_timeout;

  int checks_cnt = 0;
  int errors_cnt = 0;

  always #5 clk = ~clk;

  mem_stage #(.DMEM_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ctrlword(ex_ctrlword),
    .ex_alu_out(ex_alu_out), .ex_i_rs2(ex_i_rs2), .ex_u_imm(ex_u_imm), .ex_pc(ex_pc),
    .ex_br_en(ex_br_en), .ex_rd_addr(ex_rd_addr),
    .mem_stall(mem_stall),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_fwd_rs_addr(mem_fwd_rs_addr), .mem_fwd_rs_data(mem_fwd_rs_data),
    .wb_valid(wb_valid), .wb_ctrlword(wb_ctrlword), .wb_rd_addr(wb_rd_addr),
    .wb_data(wb_data), .mem_timeout(mem_timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic mr, input logic mw, input logic [2:0] f3, input logic rfw,
                          input regfilemux_sel_t sel, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [4:0] rd);
    ex_valid                  = 1'b1;
    ex_ctrlword.mem_read      = mr;
    ex_ctrlword.mem_write     = mw;
    ex_ctrlword.funct3        = f3;
    ex_ctrlword.regfile_write = rfw;
    ex_ctrlword.regfilemux_sel = sel;
    ex_alu_out                = alu;
    ex_i_rs2                  = rs2;
    ex_rd_addr                = rd;
  endtask

  // Non-memory op: issued now, expected in MEM/WB after the next edge
  task automatic do_alu(input string tag, input regfilemux_sel_t sel, input logic [31:0] alu,
                        input logic [4:0] rd, input logic [31:0] exp_wb);
    logic [4:0] exp_fwd;
    drive_op(1'b0, 1'b0, 3'b000, 1'b1, sel, alu, 32'h0, rd);
    #1;
    check({tag, "_nostall"}, 32'(mem_stall), 32'd0);
    tick();
    exp_fwd = (rd != 5'd0) ? rd : 5'd0;
    check({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    check({tag, "_wbdata"}, wb_data, exp_wb);
    check({tag, "_fwdaddr"}, 32'(mem_fwd_rs_addr), 32'(exp_fwd));
    $display("txn %s rd=%0d wb_data=0x%08h", tag, rd, wb_data);
  endtask

  // Memory op with the response arriving 'lat' cycles after issue
  task automatic do_mem(input string tag, input logic mr, input logic mw, input logic [2:0] f3,
                        input regfilemux_sel_t sel, input logic rfw, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] rdata,
                        input int lat, input logic [31:0] exp_addr, input logic [3:0] exp_mask,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_wb);
    int stalls;
    logic [4:0] exp_fwd;
    stalls = 0;
    drive_op(mr, mw, f3, rfw, sel, addr, rs2, rd);
    for (int i = 0; i < lat; i++) begin
      #1;
      if (mem_stall) stalls++;
      if (i == 0) begin
        check({tag, "_rw"}, 32'({dmem_read, dmem_write}), 32'({mr, mw}));
        check({tag, "_addr"}, dmem_address, exp_addr);
        check({tag, "_wmask"}, 32'(dmem_wmask), 32'(exp_mask));
        check({tag, "_wdata"}, dmem_wdata, exp_wdata);
      end else begin
        check({tag, "_bubble"}, 32'(wb_valid), 32'd0);
      end
      tick();
    end
    dmem_resp  = 1'b1;
    dmem_rdata = rdata;
    #1;
    check({tag, "_resp_stall"}, 32'(mem_stall), 32'd0);
    check({tag, "_resp_rw"}, 32'({dmem_read, dmem_write}), 32'({mr, mw}));
    check({tag, "_resp_addr"}, dmem_address, exp_addr);
    check({tag, "_stall_cycles"}, 32'(stalls), 32'(lat));
    tick();
    dmem_resp  = 1'b0;
    dmem_rdata = 32'h0;
    ex_valid   = 1'b0;
    exp_fwd = (rfw && rd != 5'd0) ? rd : 5'd0;
    check({tag, "_wbv"}, 32'(wb_valid), 32'd1);
    check({tag, "_wbdata"}, wb_data, exp_wb);
    check({tag, "_fwdaddr"}, 32'(mem_fwd_rs_addr), 32'(exp_fwd));
    $display("txn %s addr=0x%08h lat=%0d wb_data=0x%08h", tag, addr, lat, wb_data);
  endtask

  initial begin
    rst         = 1'b1;
    ex_valid    = 1'b0;
    ex_ctrlword = '0;
    ex_alu_out  = 32'h0;
    ex_i_rs2    = 32'h0;
    ex_u_imm    = 32'h0;
    ex_pc       = 32'h0;
    ex_br_en    = 1'b0;
    ex_rd_addr  = 5'd0;
    dmem_rdata  = 32'h0;
    dmem_resp   = 1'b0;

    #2;
    check("rst_wbv", 32'(wb_valid), 32'd0);
    check("rst_wbctrl", {23'h0, wb_ctrlword}, 32'h0);
    check("rst_wbdata", wb_data, 32'h0);
    check("rst_wbrd", 32'(wb_rd_addr), 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);
    check("rst_rw", 32'({dmem_read, dmem_write}), 32'd0);
    $display("txn reset");

    // Release reset and present an op for the very first rising edge
    @(negedge clk);
    rst = 1'b0;
    do_alu("alu_first", RF_ALU, 32'h1111_2222, 5'd5, 32'h1111_2222);
    check("fwd_data", mem_fwd_rs_data, 32'h1111_2222);
    ex_br_en = 1'b1;
    do_alu("br_en", RF_BR, 32'h0, 5'd6, 32'h0000_0001);
    ex_pc = 32'h0000_1000;
    do_alu("pc4_x0", RF_PC4, 32'h0, 5'd0, 32'h0000_1004);
    check("x0_fwd_data", mem_fwd_rs_data, 32'h0);
    ex_u_imm = 32'hABCD_E000;
    do_alu("uimm", RF_UIMM, 32'h0, 5'd7, 32'hABCD_E000);

    ex_valid = 1'b0;
    tick();
    check("bubble_wbv", 32'(wb_valid), 32'd0);
    check("bubble_fwd", 32'(mem_fwd_rs_addr), 32'd0);
    $display("txn bubble");

    do_mem("sw_100", 1'b0, 1'b1, 3'b010, RF_ALU, 1'b0, 32'h100, 32'hDEAD_BEEF, 5'd0, 32'h0, 3,
           32'h100, 4'b1111, 32'hDEAD_BEEF, 32'h100);
    check("sw_no_timeout", 32'(mem_timeout), 32'd0);
    do_mem("lb_103", 1'b1, 1'b0, 3'b000, RF_LOAD, 1'b1, 32'h103, 32'h0, 5'd8, 32'h80FF_FF00, 1,
           32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80);
    check("lb_fwd_data", mem_fwd_rs_data, 32'hFFFF_FF80);
    do_mem("lbu_103", 1'b1, 1'b0, 3'b100, RF_LOAD, 1'b1, 32'h103, 32'h0, 5'd8, 32'h80FF_FF00, 1,
           32'h100, 4'b0000, 32'h0, 32'h0000_0080);
    do_mem("sh_102", 1'b0, 1'b1, 3'b001, RF_ALU, 1'b0, 32'h102, 32'h0000_1234, 5'd0, 32'h0, 2,
           32'h100, 4'b1100, 32'h1234_1234, 32'h102);
    do_mem("lh_102", 1'b1, 1'b0, 3'b001, RF_LOAD, 1'b1, 32'h102, 32'h0, 5'd10, 32'h8001_7FFF, 1,
           32'h100, 4'b0000, 32'h0, 32'hFFFF_8001);
    do_mem("lhu_102", 1'b1, 1'b0, 3'b101, RF_LOAD, 1'b1, 32'h102, 32'h0, 5'd10, 32'h8001_7FFF, 1,
           32'h100, 4'b0000, 32'h0, 32'h0000_8001);
    do_mem("lw_200", 1'b1, 1'b0, 3'b010, RF_LOAD, 1'b1, 32'h200, 32'h0, 5'd11, 32'hCAFE_F00D, 2,
           32'h200, 4'b0000, 32'h0, 32'hCAFE_F00D);
    do_mem("sb_101", 1'b0, 1'b1, 3'b000, RF_ALU, 1'b0, 32'h101, 32'h0000_00AB, 5'd0, 32'h0, 1,
           32'h100, 4'b0010, 32'hABAB_ABAB, 32'h101);
    do_mem("lb_101", 1'b1, 1'b0, 3'b000, RF_LOAD, 1'b1, 32'h101, 32'h0, 5'd12, 32'h0000_7F00, 1,
           32'h100, 4'b0000, 32'h0, 32'h0000_007F);
    do_mem("lh_100_x0", 1'b1, 1'b0, 3'b001, RF_LOAD, 1'b1, 32'h100, 32'h0, 5'd0, 32'h0000_FFFE, 1,
           32'h100, 4'b0000, 32'h0, 32'hFFFF_FFFE);

    // A response with nothing outstanding must not disturb anything
    ex_valid  = 1'b0;
    dmem_resp = 1'b1;
    #1;
    check("stray_stall", 32'(mem_stall), 32'd0);
    tick();
    dmem_resp = 1'b0;
    check("stray_wbv", 32'(wb_valid), 32'd0);
    $display("txn stray_resp");

    // Reset in the middle of an outstanding load
    drive_op(1'b1, 1'b0, 3'b010, 1'b1, RF_LOAD, 32'h300, 32'h0, 5'd9);
    tick();
    check("rstwait_read", 32'(dmem_read), 32'd1);
    check("rstwait_stall", 32'(mem_stall), 32'd1);
    rst = 1'b1;
    #1;
    check("rstwait_read_drop", 32'(dmem_read), 32'd0);
    check("rstwait_wbv", 32'(wb_valid), 32'd0);
    ex_valid = 1'b0;
    tick();
    rst       = 1'b0;
    dmem_resp = 1'b1;
    #1;
    check("rstwait_stray_read", 32'(dmem_read), 32'd0);
    check("rstwait_stray_stall", 32'(mem_stall), 32'd0);
    tick();
    dmem_resp = 1'b0;
    check("rstwait_stray_wbv", 32'(wb_valid), 32'd0);
    $display("txn reset_mid_wait");
    do_mem("lw_after_rst", 1'b1, 1'b0, 3'b010, RF_LOAD, 1'b1, 32'h304, 32'h0, 5'd13, 32'h1234_5678, 1,
           32'h304, 4'b0000, 32'h0, 32'h1234_5678);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned word load is squashed: no request, no stall, no regfile write
    drive_op(1'b1, 1'b0, 3'b010, 1'b1, RF_LOAD, 32'h102, 32'h0, 5'd14);
    #1;
    check("misalign_read", 32'(dmem_read), 32'd0);
    check("misalign_stall", 32'(mem_stall), 32'd0);
    tick();
    ex_valid = 1'b0;
    check("misalign_wbv", 32'(wb_valid), 32'd1);
    check("misalign_rfw", 32'(wb_ctrlword.regfile_write), 32'd0);
    check("misalign_fwd", 32'(mem_fwd_rs_addr), 32'd0);
    $display("txn misaligned_lw");
`endif

    // Watchdog: no response; flag rises after 4 WAIT cycles and sticks
    drive_op(1'b1, 1'b0, 3'b010, 1'b1, RF_LOAD, 32'h400, 32'h0, 5'd15);
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 3) check("wd_before", 32'(mem_timeout), 32'd0);
      if (k == 4) check("wd_set", 32'(mem_timeout), 32'd1);
      if (k == 6) begin
        check("wd_sticky", 32'(mem_timeout), 32'd1);
        check("wd_still_stall", 32'(mem_stall), 32'd1);
      end
    end
    dmem_resp  = 1'b1;
    dmem_rdata = 32'h0BAD_F00D;
    tick();
    dmem_resp = 1'b0;
    ex_valid  = 1'b0;
    check("wd_late_wbdata", wb_data, 32'h0BAD_F00D);
    check("wd_after_resp", 32'(mem_timeout), 32'd1);
    rst = 1'b1;
    #1;
    check("wd_rst_clear", 32'(mem_timeout), 32'd0);
    rst = 1'b0;
    $display("txn watchdog");

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
